if_fetch_unit: RTL and testbench

Instruction-fetch stage and producing end of the IF/ID pipeline register interface. It owns the PC, issues single-outstanding requests to instruction memory, and buffers each returned word. It drives Inst, PC_Plus4, IFIDWrite and flush into IF/ID, honouring hazard stalls and branch/jump redirects from later stages.

---
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time, buffers the word into IF/ID.
// Optional: define IF_STALL_CNT_EN to add the saturating stall_cycles counter output.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] PC_Plus4,
    output logic        IFIDWrite,
    output logic        flush
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        READY,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;

    assign imem_addr = pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        IFIDWrite  = 1'b0;
        flush      = redirect;
        case (state)
            IDLE:  state_next = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) state_next = WAIT;
            end
            WAIT:  if (imem_rvalid) state_next = READY;
            READY: begin
                if (!stall) begin
                    IFIDWrite  = 1'b1;
                    state_next = REQ;
                end
            end
            DRAIN: if (imem_rvalid) state_next = REQ;
            default: state_next = IDLE;
        endcase

        // A redirect must still retire any request already accepted by memory before refetching.
        if (redirect) begin
            IFIDWrite = 1'b0;
            case (state)
                REQ:     state_next = imem_ready  ? DRAIN : REQ;
                WAIT:    state_next = imem_rvalid ? REQ   : DRAIN;
                DRAIN:   state_next = imem_rvalid ? REQ   : DRAIN;
                default: state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            Inst     <= 32'h0;
            PC_Plus4 <= 32'h0;
        end else begin
            if (redirect) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (IFIDWrite) begin
                pc <= PC_Plus4;
            end
            if (state == WAIT && imem_rvalid && !redirect) begin
                Inst     <= imem_rdata;
                PC_Plus4 <= pc + 32'd4;
            end
        end
    end

`ifdef IF_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= 32'h0;
        end else if (state == READY && stall && !redirect && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model plus program-order scoreboard of expected IF/ID writes.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Inst;
    logic [31:0] PC_Plus4;
    logic        IFIDWrite;
    logic        flush;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .Inst(Inst),
        .PC_Plus4(PC_Plus4),
        .IFIDWrite(IFIDWrite),
        .flush(flush)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    int          nChecks = 0;
    int          nFails = 0;
    int          commits = 0;
    logic [31:0] expQ[$];

    int          readyPct = 100;
    int          stallPct = 0;
    int          redirectPct = 0;
    int          spuriousPct = 0;
    int          maxLat = 0;
    int          memLatNext = -1;
    logic        forceStall = 1'b0;
    logic        forceRedirect = 1'b0;
    logic [31:0] forceTarget = 32'h0;

    logic        memOutstanding = 1'b0;
    logic        memJustAccepted = 1'b0;
    logic [31:0] memAddr = 32'h0;
    int          memCount = 0;
    logic        prevPending = 1'b0;
    logic [31:0] prevAddr = 32'h0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string what);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // One cycle of stimulus at the falling edge: memory responder, request acceptance, hazard inputs.
    task automatic applyStimulus();
        @(negedge clock);
        memJustAccepted = 1'b0;
        if (reset_n) begin
            if (prevPending) begin
                checkOutput("req_hold", {31'b0, imem_req}, 32'd1);
                checkOutput("addr_hold", imem_addr, prevAddr);
            end
            if (imem_req) begin
                nChecks++;
                if (memOutstanding) begin
                    nFails++;
                    $display("[TB] FAIL single_outstanding: got request %h, required none while %h pending",
                             imem_addr, memAddr);
                end
            end
        end
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (memOutstanding) begin
            if (memCount == 0) begin
                imem_rvalid    = 1'b1;
                imem_rdata     = memWord(memAddr);
                memOutstanding = 1'b0;
            end else begin
                memCount--;
            end
        end else if ($urandom_range(99) < spuriousPct) begin
            imem_rvalid = 1'b1;
        end
        imem_ready = ($urandom_range(99) < readyPct);
        if (reset_n && imem_req && imem_ready) begin
            memOutstanding  = 1'b1;
            memJustAccepted = 1'b1;
            memAddr         = imem_addr;
            memCount        = (memLatNext >= 0) ? memLatNext : int'($urandom_range(maxLat));
        end
        stall       = forceStall || ($urandom_range(99) < stallPct);
        redirect    = forceRedirect || ($urandom_range(99) < redirectPct);
        redirect_pc = forceRedirect ? forceTarget : $urandom;
        if (redirect && reset_n) begin
            expQ.delete();
            expQ.push_back(redirect_pc & 32'hFFFF_FFFC);
        end
        prevPending = reset_n && imem_req && !imem_ready && !redirect;
        prevAddr    = imem_addr;
    endtask

    task automatic resetDut();
        reset_n        = 1'b0;
        stall          = 1'b0;
        redirect       = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        memOutstanding = 1'b0;
        prevPending    = 1'b0;
        #1;
        checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
        checkOutput("rst_addr", imem_addr, RESET_PC);
        checkOutput("rst_inst", Inst, 32'd0);
        checkOutput("rst_pc4", PC_Plus4, 32'd0);
        checkOutput("rst_ifidwrite", {31'b0, IFIDWrite}, 32'd0);
        checkOutput("rst_flush", {31'b0, flush}, 32'd0);
        repeat (2) applyStimulus();
        memOutstanding = 1'b0;
        expQ.delete();
        expQ.push_back(RESET_PC);
        reset_n = 1'b1;
    endtask

    task automatic runUntilWrite(input string name);
        int n = 0;
        do begin
            applyStimulus();
            #1;
            n++;
        end while (!IFIDWrite && n < 20);
        if (!IFIDWrite) failNow(name, "got no IFIDWrite, required one within 20 cycles");
    endtask

    task automatic runUntilReq(input string name);
        int n = 0;
        do begin
            applyStimulus();
            #1;
            n++;
        end while (!imem_req && n < 20);
        if (!imem_req) failNow(name, "got no imem_req, required one within 20 cycles");
    endtask

    // Monitor: every IF/ID write must be the next instruction in program order.
    initial begin
        logic [31:0] pc;
        forever begin
            @(negedge clock);
            #2;
            if (reset_n) begin
                checkOutput("flush_eq_redirect", {31'b0, flush}, {31'b0, redirect});
                if (IFIDWrite) begin
                    checkOutput("ifid_hazard", {30'b0, stall, redirect}, 32'd0);
                    if (expQ.size() == 0) begin
                        failNow("sb_empty", "got IFIDWrite, required none (no expected fetch)");
                    end else begin
                        pc = expQ.pop_front();
                        checkOutput("sb_inst", Inst, memWord(pc));
                        checkOutput("sb_pc_plus4", PC_Plus4, pc + 32'd4);
                        expQ.push_back(pc + 32'd4);
                        commits++;
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        logic seenAccept;
        #2;
        resetDut();

        for (int i = 1; i <= 9; i++) begin
            applyStimulus();
            #1;
            if (i == 1) begin
                checkOutput("first_req", {31'b0, imem_req}, 32'd1);
                checkOutput("first_addr", imem_addr, RESET_PC);
            end
            checkOutput("cadence", {31'b0, IFIDWrite}, (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i % 3 == 0) begin
                checkOutput("cad_inst", Inst, 32'h100 + 32'(4 * (i / 3 - 1)));
                checkOutput("cad_pc4", PC_Plus4, 32'(4 * (i / 3)));
            end
        end

        applyStimulus();
        applyStimulus();
        forceStall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            #1;
            checkOutput("stall_ifidwrite", {31'b0, IFIDWrite}, 32'd0);
            checkOutput("stall_req", {31'b0, imem_req}, 32'd0);
            checkOutput("stall_inst", Inst, 32'h10C);
            checkOutput("stall_pc4", PC_Plus4, 32'h10);
        end
        forceStall = 1'b0;
        applyStimulus();
        #1;
        checkOutput("stall_resume", {31'b0, IFIDWrite}, 32'd1);
`ifdef IF_STALL_CNT_EN
        checkOutput("stall_cycles", stall_cycles, 32'd4);
`endif

        memLatNext = 2;
        applyStimulus();
        #1;
        checkOutput("wait_req_addr", imem_addr, 32'h10);
        memLatNext    = -1;
        forceRedirect = 1'b1;
        forceTarget   = 32'h0000_0042;
        applyStimulus();
        #1;
        checkOutput("redir_flush", {31'b0, flush}, 32'd1);
        checkOutput("redir_ifidwrite", {31'b0, IFIDWrite}, 32'd0);
        forceRedirect = 1'b0;
        runUntilReq("redir_req");
        checkOutput("redir_addr", imem_addr, 32'h40);
        runUntilWrite("redir_write");
        checkOutput("redir_pc4", PC_Plus4, 32'h44);

        applyStimulus();
        applyStimulus();
        forceStall    = 1'b1;
        forceRedirect = 1'b1;
        forceTarget   = 32'h0000_0200;
        applyStimulus();
        #1;
        checkOutput("rs_flush", {31'b0, flush}, 32'd1);
        checkOutput("rs_ifidwrite", {31'b0, IFIDWrite}, 32'd0);
        checkOutput("rs_inst", Inst, 32'h144);
        forceStall    = 1'b0;
        forceRedirect = 1'b0;
        applyStimulus();
        #1;
        checkOutput("rs_req", {31'b0, imem_req}, 32'd1);
        checkOutput("rs_addr", imem_addr, 32'h200);
        runUntilWrite("rs_write");
        checkOutput("rs_pc4", PC_Plus4, 32'h204);

        forceRedirect = 1'b1;
        forceTarget   = 32'hFFFF_FFFE;
        applyStimulus();
        forceRedirect = 1'b0;
        runUntilReq("wrap_req");
        checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        runUntilWrite("wrap_write");
        checkOutput("wrap_pc4", PC_Plus4, 32'h0);
        checkOutput("wrap_inst", Inst, 32'h0000_00FC);
        runUntilReq("wrap_next_req");
        checkOutput("wrap_next_addr", imem_addr, 32'h0);

        readyPct    = 70;
        stallPct    = 25;
        redirectPct = 5;
        spuriousPct = 10;
        maxLat      = 3;
        c0          = commits;
        repeat (3000) applyStimulus();
        nChecks++;
        if (commits - c0 < 100) begin
            nFails++;
            $display("[TB] FAIL progress: got %0d commits, required at least 100", commits - c0);
        end

        readyPct    = 100;
        stallPct    = 0;
        redirectPct = 0;
        spuriousPct = 0;
        memLatNext  = 3;
        seenAccept  = 1'b0;
        for (int n = 0; n < 30; n++) begin
            applyStimulus();
            if (memJustAccepted) seenAccept = 1'b1;
            else if (seenAccept && memOutstanding) break;
        end
        if (!(seenAccept && memOutstanding && !memJustAccepted))
            failNow("reach_wait", "got no WAIT cycle, required one within 30 cycles");
        #3;
        resetDut();
        runUntilReq("post_rst_req");
        checkOutput("post_rst_addr", imem_addr, RESET_PC);
        runUntilWrite("post_rst_write");
        checkOutput("post_rst_pc4", PC_Plus4, RESET_PC + 32'd4);

        repeat (3) applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
